// File: rtl/rv32_pkg.sv
// Shared encodings for the RV32I execute/control slice:
// opcodes, ALU operations, branch kinds, immediate formats, operand selects.
package rv32_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SLL  = 4'b0001,
      ALU_SLT  = 4'b0010,
      ALU_CPB  = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_OR   = 4'b0110,
      ALU_AND  = 4'b0111,
      ALU_SUB  = 4'b1000,
      ALU_SLTU = 4'b1010,
      ALU_SRA  = 4'b1101
   } alu_ctr_e;

   typedef enum logic [2:0] {
      BR_NONE = 3'b000,
      BR_JAL  = 3'b001,
      BR_JALR = 3'b010,
      BR_EQ   = 3'b100,
      BR_NE   = 3'b101,
      BR_LT   = 3'b110,
      BR_GE   = 3'b111
   } br_e;

   typedef enum logic [2:0] {
      EXT_I = 3'b000,
      EXT_U = 3'b001,
      EXT_S = 3'b010,
      EXT_B = 3'b011,
      EXT_J = 3'b100
   } ext_e;

   typedef enum logic {
      A_RS1 = 1'b0,
      A_PC  = 1'b1
   } asrc_e;

   typedef enum logic [1:0] {
      B_RS2  = 2'b00,
      B_IMM  = 2'b01,
      B_FOUR = 2'b10,
      B_ZERO = 2'b11
   } bsrc_e;

   // Register/immediate ALU op; sub only exists for the register form.
   function automatic alu_ctr_e alu_func(
      input logic [2:0] f3,
      input logic       f7b5,
      input logic       is_reg
   );
      alu_ctr_e r;
      case (f3)
         3'b000:  r = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
         3'b001:  r = ALU_SLL;
         3'b010:  r = ALU_SLT;
         3'b011:  r = ALU_SLTU;
         3'b100:  r = ALU_XOR;
         3'b101:  r = f7b5 ? ALU_SRA : ALU_SRL;
         3'b110:  r = ALU_OR;
         default: r = ALU_AND;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/rv32_exec_ctrl_if.sv
// Decode-side bundle of the execute/control slice: instruction fields
// and operands in, control, ALU result and PC out.
interface rv32_exec_ctrl_if;
   logic [6:0]  op;
   logic [2:0]  func3;
   logic [6:0]  func7;
   logic [31:0] imm;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [2:0]  ext_op;
   logic        reg_wr;
   logic        mem_to_reg;
   logic        mem_rd;
   logic        mem_wr;
   logic [2:0]  mem_op;
   logic [31:0] alu_out;
   logic        less;
   logic        zero;
   logic [31:0] pc;
   logic [31:0] next_pc;

   modport master (
      output op, func3, func7, imm, rs1_data, rs2_data,
      input  ext_op, reg_wr, mem_to_reg, mem_rd, mem_wr, mem_op,
      input  alu_out, less, zero, pc, next_pc
   );

   modport slave (
      input  op, func3, func7, imm, rs1_data, rs2_data,
      output ext_op, reg_wr, mem_to_reg, mem_rd, mem_wr, mem_op,
      output alu_out, less, zero, pc, next_pc
   );
endinterface

// File: rtl/rv32_alu.sv
// Combinational RV32I ALU with compare flags.
// less follows the signedness chosen by the top bit of the op code.
module rv32_alu
   import rv32_pkg::*;
(
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  alu_ctr_e    i_ctr,
   output logic [31:0] o_res,
   output logic        o_less,
   output logic        o_zero
);

   logic [4:0] w_sh;
   logic       w_lt_s;
   logic       w_lt_u;

   assign w_sh   = i_b[4:0];
   assign w_lt_s = $signed(i_a) < $signed(i_b);
   assign w_lt_u = i_a < i_b;
   assign o_less = i_ctr[3] ? w_lt_u : w_lt_s;
   assign o_zero = (i_a == i_b);

   always_comb begin
      o_res = 32'd0;
      unique case (i_ctr)
         ALU_ADD:  o_res = i_a + i_b;
         ALU_SUB:  o_res = i_a - i_b;
         ALU_SLL:  o_res = i_a << w_sh;
         ALU_SRL:  o_res = i_a >> w_sh;
         ALU_SRA:  o_res = $unsigned($signed(i_a) >>> w_sh);
         ALU_SLT:  o_res = {31'd0, w_lt_s};
         ALU_SLTU: o_res = {31'd0, w_lt_u};
         ALU_CPB:  o_res = i_b;
         ALU_XOR:  o_res = i_a ^ i_b;
         ALU_OR:   o_res = i_a | i_b;
         ALU_AND:  o_res = i_a & i_b;
         default:  o_res = 32'd0;
      endcase
   end

endmodule

// File: rtl/rv32_exec_ctrl.sv
// Single-cycle RV32I execute/control slice: decode to control,
// ALU, branch resolution and the program counter.
module rv32_exec_ctrl
   import rv32_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input logic            clk,
   input logic            rst,
   rv32_exec_ctrl_if.slave bus
);

   ext_e        w_ext;
   logic        w_reg_wr;
   logic        w_mem_to_reg;
   logic        w_mem_rd;
   logic        w_mem_wr;
   logic [2:0]  w_mem_op;
   asrc_e       w_a_src;
   bsrc_e       w_b_src;
   alu_ctr_e    w_alu_ctr;
   br_e         w_br;
   logic [31:0] w_alu_a;
   logic [31:0] w_alu_b;
   logic [31:0] w_alu_res;
   logic        w_less;
   logic        w_zero;
   logic        w_pc_a;
   logic        w_pc_b;
   logic [31:0] w_tgt;
   logic [31:0] w_next_pc;
   logic [31:0] r_pc;
   logic        w_f7b5;

   assign w_f7b5 = bus.func7[5];

   always_comb begin
      w_ext        = EXT_I;
      w_reg_wr     = 1'b0;
      w_mem_to_reg = 1'b0;
      w_mem_rd     = 1'b0;
      w_mem_wr     = 1'b0;
      w_mem_op     = 3'b000;
      w_a_src      = A_RS1;
      w_b_src      = B_RS2;
      w_alu_ctr    = ALU_ADD;
      w_br         = BR_NONE;
      unique case (1'b1)
         (bus.op == OP_LUI): begin
            w_ext     = EXT_U;
            w_reg_wr  = 1'b1;
            w_b_src   = B_IMM;
            w_alu_ctr = ALU_CPB;
         end
         (bus.op == OP_AUIPC): begin
            w_ext    = EXT_U;
            w_reg_wr = 1'b1;
            w_a_src  = A_PC;
            w_b_src  = B_IMM;
         end
         (bus.op == OP_JAL): begin
            w_ext    = EXT_J;
            w_reg_wr = 1'b1;
            w_a_src  = A_PC;
            w_b_src  = B_FOUR;
            w_br     = BR_JAL;
         end
         (bus.op == OP_JALR): begin
            w_reg_wr = 1'b1;
            w_a_src  = A_PC;
            w_b_src  = B_FOUR;
            w_br     = BR_JALR;
         end
         (bus.op == OP_BRANCH): begin
            w_ext = EXT_B;
            case (bus.func3)
               3'b000: begin w_alu_ctr = ALU_SUB;  w_br = BR_EQ; end
               3'b001: begin w_alu_ctr = ALU_SUB;  w_br = BR_NE; end
               3'b100: begin w_alu_ctr = ALU_SLT;  w_br = BR_LT; end
               3'b101: begin w_alu_ctr = ALU_SLT;  w_br = BR_GE; end
               3'b110: begin w_alu_ctr = ALU_SLTU; w_br = BR_LT; end
               3'b111: begin w_alu_ctr = ALU_SLTU; w_br = BR_GE; end
               default: w_br = BR_NONE;
            endcase
         end
         (bus.op == OP_LOAD): begin
            w_reg_wr     = 1'b1;
            w_mem_rd     = 1'b1;
            w_mem_to_reg = 1'b1;
            w_b_src      = B_IMM;
            w_mem_op     = bus.func3;
         end
         (bus.op == OP_STORE): begin
            w_ext    = EXT_S;
            w_mem_wr = 1'b1;
            w_b_src  = B_IMM;
            w_mem_op = bus.func3;
         end
         (bus.op == OP_IMM): begin
            w_reg_wr  = 1'b1;
            w_b_src   = B_IMM;
            w_alu_ctr = alu_func(bus.func3, w_f7b5, 1'b0);
         end
         (bus.op == OP_REG): begin
            w_reg_wr  = 1'b1;
            w_alu_ctr = alu_func(bus.func3, w_f7b5, 1'b1);
         end
         default: ;
      endcase
   end

   assign w_alu_a = (w_a_src == A_PC) ? r_pc : bus.rs1_data;

   always_comb begin
      w_alu_b = 32'd0;
      unique case (w_b_src)
         B_RS2:   w_alu_b = bus.rs2_data;
         B_IMM:   w_alu_b = bus.imm;
         B_FOUR:  w_alu_b = 32'd4;
         default: w_alu_b = 32'd0;
      endcase
   end

   rv32_alu u_alu (
      .i_a    (w_alu_a),
      .i_b    (w_alu_b),
      .i_ctr  (w_alu_ctr),
      .o_res  (w_alu_res),
      .o_less (w_less),
      .o_zero (w_zero)
   );

   always_comb begin
      w_pc_a = 1'b0;
      w_pc_b = 1'b0;
      unique case (w_br)
         BR_JAL:  w_pc_a = 1'b1;
         BR_JALR: begin w_pc_a = 1'b1; w_pc_b = 1'b1; end
         BR_EQ:   w_pc_a = w_zero;
         BR_NE:   w_pc_a = !w_zero;
         BR_LT:   w_pc_a = w_less;
         BR_GE:   w_pc_a = !w_less;
         default: ;
      endcase
   end

   // jalr targets are halfword-aligned by clearing bit 0
   assign w_tgt = (w_pc_a ? bus.imm : 32'd4) + (w_pc_b ? bus.rs1_data : r_pc);
   assign w_next_pc = (w_br == BR_JALR) ? {w_tgt[31:1], 1'b0} : w_tgt;

   always_ff @(posedge clk) begin
      if (!rst) r_pc <= RESET_PC;
      else      r_pc <= w_next_pc;
   end

   assign bus.ext_op     = w_ext;
   assign bus.reg_wr     = w_reg_wr;
   assign bus.mem_to_reg = w_mem_to_reg;
   assign bus.mem_rd     = w_mem_rd;
   assign bus.mem_wr     = w_mem_wr;
   assign bus.mem_op     = w_mem_op;
   assign bus.alu_out    = w_alu_res;
   assign bus.less       = w_less;
   assign bus.zero       = w_zero;
   assign bus.pc         = r_pc;
   assign bus.next_pc    = w_next_pc;

endmodule

// File: tb/tb_rv32_exec_ctrl.sv
// Directed bench for rv32_exec_ctrl: decode, ALU, branch and PC
// sequencing with hand-computed expected values.
module tb_rv32_exec_ctrl;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   rv32_exec_ctrl_if bus ();

   rv32_exec_ctrl #(.RESET_PC(32'h8000_0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm,
                        input logic [31:0] a, input logic [31:0] b);
      bus.op       = op;
      bus.func3    = f3;
      bus.func7    = f7;
      bus.imm      = imm;
      bus.rs1_data = a;
      bus.rs2_data = b;
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b0;
      drive(7'b0010011, 3'b000, 7'h00, 32'h0, 32'h0, 32'h0);
      @(posedge clk); #1;
      chk("reset_pc", bus.pc, 32'h8000_0000);

      // held in reset: pc stays 0x80000000 while combinational paths are probed
      drive(7'b0010011, 3'b000, 7'h00, 32'hFFFF_FFFD, 32'd5, 32'd0);
      chk("addi_res", bus.alu_out, 32'd2);
      chk("addi_wr", {31'd0, bus.reg_wr}, 32'd1);
      chk("addi_ext", {29'd0, bus.ext_op}, 32'd0);
      chk("addi_npc", bus.next_pc, 32'h8000_0004);

      drive(7'b0110011, 3'b101, 7'h20, 32'h0, 32'h8000_0000, 32'd4);
      chk("sra", bus.alu_out, 32'hF800_0000);
      drive(7'b0110011, 3'b101, 7'h00, 32'h0, 32'h8000_0000, 32'd4);
      chk("srl", bus.alu_out, 32'h0800_0000);

      drive(7'b0110011, 3'b000, 7'h20, 32'h0, 32'd5, 32'd7);
      chk("sub", bus.alu_out, 32'hFFFF_FFFE);
      chk("sub_less", {31'd0, bus.less}, 32'd1);
      drive(7'b0010011, 3'b000, 7'h20, 32'd7, 32'd5, 32'd0);
      chk("addi_f7", bus.alu_out, 32'd12);

      drive(7'b1100011, 3'b000, 7'h00, 32'h10, 32'd7, 32'd7);
      chk("beq_t_npc", bus.next_pc, 32'h8000_0010);
      chk("beq_zero", {31'd0, bus.zero}, 32'd1);
      chk("beq_ext", {29'd0, bus.ext_op}, 32'd3);
      chk("beq_wr", {31'd0, bus.reg_wr}, 32'd0);
      drive(7'b1100011, 3'b000, 7'h00, 32'h10, 32'd7, 32'd8);
      chk("beq_nt_npc", bus.next_pc, 32'h8000_0004);
      drive(7'b1100011, 3'b001, 7'h00, 32'h10, 32'd7, 32'd8);
      chk("bne_t_npc", bus.next_pc, 32'h8000_0010);

      drive(7'b1100011, 3'b110, 7'h00, 32'h10, 32'hFFFF_FFFF, 32'd1);
      chk("bltu_npc", bus.next_pc, 32'h8000_0004);
      chk("bltu_less", {31'd0, bus.less}, 32'd0);
      chk("bltu_res", bus.alu_out, 32'd0);
      drive(7'b1100011, 3'b100, 7'h00, 32'h10, 32'hFFFF_FFFF, 32'd1);
      chk("blt_npc", bus.next_pc, 32'h8000_0010);
      chk("blt_res", bus.alu_out, 32'd1);
      drive(7'b1100011, 3'b111, 7'h00, 32'h10, 32'hFFFF_FFFF, 32'd1);
      chk("bgeu_npc", bus.next_pc, 32'h8000_0010);

      drive(7'b1100111, 3'b000, 7'h00, 32'h0, 32'h8000_1001, 32'd0);
      chk("jalr_npc", bus.next_pc, 32'h8000_1000);
      chk("jalr_link", bus.alu_out, 32'h8000_0004);
      chk("jalr_wr", {31'd0, bus.reg_wr}, 32'd1);
      drive(7'b1101111, 3'b000, 7'h00, 32'h100, 32'h0, 32'd0);
      chk("jal_npc", bus.next_pc, 32'h8000_0100);
      chk("jal_ext", {29'd0, bus.ext_op}, 32'd4);
      chk("jal_link", bus.alu_out, 32'h8000_0004);

      drive(7'b0100011, 3'b010, 7'h00, 32'hFFFF_FFFC, 32'h1000, 32'h55);
      chk("sw_mwr", {31'd0, bus.mem_wr}, 32'd1);
      chk("sw_wr", {31'd0, bus.reg_wr}, 32'd0);
      chk("sw_addr", bus.alu_out, 32'h0000_0FFC);
      chk("sw_mop", {29'd0, bus.mem_op}, 32'd2);
      chk("sw_ext", {29'd0, bus.ext_op}, 32'd2);

      drive(7'b0000011, 3'b100, 7'h00, 32'd8, 32'h2000, 32'h0);
      chk("lbu_mrd", {31'd0, bus.mem_rd}, 32'd1);
      chk("lbu_m2r", {31'd0, bus.mem_to_reg}, 32'd1);
      chk("lbu_mop", {29'd0, bus.mem_op}, 32'd4);
      chk("lbu_addr", bus.alu_out, 32'h0000_2008);

      drive(7'b0110111, 3'b000, 7'h00, 32'h1234_5000, 32'hDEAD, 32'h0);
      chk("lui", bus.alu_out, 32'h1234_5000);
      chk("lui_ext", {29'd0, bus.ext_op}, 32'd1);
      drive(7'b0010111, 3'b000, 7'h00, 32'h0000_1000, 32'h0, 32'h0);
      chk("auipc", bus.alu_out, 32'h8000_1000);

      drive(7'b1110011, 3'b000, 7'h00, 32'h40, 32'h1, 32'h1);
      chk("sys_wr", {30'd0, bus.reg_wr, bus.mem_wr}, 32'd0);
      chk("sys_npc", bus.next_pc, 32'h8000_0004);

      // release reset with addi and let pc advance
      drive(7'b0010011, 3'b000, 7'h00, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("pc_step1", bus.pc, 32'h8000_0004);
      @(posedge clk); #1;
      chk("pc_step2", bus.pc, 32'h8000_0008);

      drive(7'b1101111, 3'b000, 7'h00, 32'h20, 32'h0, 32'h0);
      @(negedge clk);
      @(posedge clk); #1;
      chk("pc_jal", bus.pc, 32'h8000_0028);

      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("pc_rerst", bus.pc, 32'h8000_0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
